// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU bus.
// Holds a DEPTH x 16 unified instruction/data RAM that a boot loader fills
// from a host byte stream (high byte first). Once the image ends, the CPU is
// released through cpu_run and may write the low byte of any word.
// Optional feature macro: MMIO_EN -- when defined, address MMIO_ADDR is an
// 8-bit output port (io_out) instead of RAM.
//
// state   | meaning
// --------+------------------------------------------------
// LOAD_HI | waiting for high byte of next word
// LOAD_LO | high byte buffered, waiting for low byte
// RUN     | loader finished, CPU owns the RAM
module mem_responder #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] MMIO_ADDR = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_valid,
  input  logic [7:0]        host_byte,
  input  logic              host_last,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] add_out,
  input  logic [7:0]        data_out,
  input  logic              MW,
  output logic [15:0]       data_in,
  output logic              cpu_run,
  output logic [ADDR_W:0]   load_words,
  output logic              overflow
`ifdef MMIO_EN
  ,
  output logic [7:0]        io_out
`endif
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LW_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ld_addr, ld_addr_nxt;
  logic [7:0]        hi_buf, hi_buf_nxt;
  logic [ADDR_W:0]   lw_nxt, lw_inc;
  logic              ov_nxt;
  logic              we_hi, we_lo;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic [15:0]       mem [DEPTH];

`ifdef MMIO_EN
  logic       mmio_hit;
  logic [7:0] io_nxt;
  assign mmio_hit = (add_out == MMIO_ADDR);
`else
  logic unused_mmio_addr;
  assign unused_mmio_addr = ^MMIO_ADDR;
`endif

  // word counter saturates at DEPTH so wrapping loads still report a full RAM
  assign lw_inc = (load_words == LW_MAX) ? load_words : load_words + 1'b1;

  // next-state, loader datapath and RAM write port selection
  always_comb begin
    state_nxt   = state;
    ld_addr_nxt = ld_addr;
    hi_buf_nxt  = hi_buf;
    lw_nxt      = load_words;
    ov_nxt      = overflow;
    we_hi       = 1'b0;
    we_lo       = 1'b0;
    waddr       = ld_addr;
    wdata       = {hi_buf, host_byte};
    host_ready  = 1'b0;
`ifdef MMIO_EN
    io_nxt      = io_out;
`endif
    case (state)
      LOAD_HI: begin
        host_ready = 1'b1;
        if (host_valid) begin
          hi_buf_nxt = host_byte;
          if (host_last) begin
            // odd-length image: final byte becomes a high byte, low zero-filled
            we_hi     = 1'b1;
            we_lo     = 1'b1;
            wdata     = {host_byte, 8'h00};
            lw_nxt    = lw_inc;
            state_nxt = RUN;
          end else begin
            state_nxt = LOAD_LO;
          end
        end
      end
      LOAD_LO: begin
        host_ready = 1'b1;
        if (host_valid) begin
          we_hi       = 1'b1;
          we_lo       = 1'b1;
          wdata       = {hi_buf, host_byte};
          ld_addr_nxt = ld_addr + 1'b1;
          lw_nxt      = lw_inc;
          if (ld_addr == '1) ov_nxt = 1'b1;
          state_nxt   = host_last ? RUN : LOAD_HI;
        end
      end
      RUN: begin
        if (MW) begin
`ifdef MMIO_EN
          if (mmio_hit) begin
            io_nxt = data_out;
          end else begin
            we_lo = 1'b1;
            waddr = add_out;
            wdata = {8'h00, data_out};
          end
`else
          we_lo = 1'b1;
          waddr = add_out;
          wdata = {8'h00, data_out};
`endif
        end
      end
      default: state_nxt = LOAD_HI;
    endcase
  end

  // state and loader registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD_HI;
      ld_addr    <= '0;
      hi_buf     <= 8'h00;
      cpu_run    <= 1'b0;
      load_words <= '0;
      overflow   <= 1'b0;
`ifdef MMIO_EN
      io_out     <= 8'h00;
`endif
    end else begin
      state      <= state_nxt;
      ld_addr    <= ld_addr_nxt;
      hi_buf     <= hi_buf_nxt;
      cpu_run    <= (state_nxt == RUN);
      load_words <= lw_nxt;
      overflow   <= ov_nxt;
`ifdef MMIO_EN
      io_out     <= io_nxt;
`endif
    end
  end

  // RAM byte-lane writes; contents survive reset, writes blocked while in reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (we_hi) mem[waddr][15:8] <= wdata[15:8];
      if (we_lo) mem[waddr][7:0]  <= wdata[7:0];
    end
  end

  // asynchronous read so the single-cycle CPU sees the word on the same edge
`ifdef MMIO_EN
  assign data_in = mmio_hit ? {8'h00, io_out} : mem[add_out];
`else
  assign data_in = mem[add_out];
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with hand-computed
// expectations. Inputs change and outputs are sampled on the falling edge.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_valid;
  logic [7:0]  host_byte;
  logic        host_last;
  logic        host_ready;
  logic [7:0]  add_out;
  logic [7:0]  data_out;
  logic        MW;
  logic [15:0] data_in;
  logic        cpu_run;
  logic [8:0]  load_words;
  logic        overflow;
`ifdef MMIO_EN
  logic [7:0]  io_out;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_valid (host_valid),
    .host_byte  (host_byte),
    .host_last  (host_last),
    .host_ready (host_ready),
    .add_out    (add_out),
    .data_out   (data_out),
    .MW         (MW),
    .data_in    (data_in),
    .cpu_run    (cpu_run),
    .load_words (load_words),
    .overflow   (overflow)
`ifdef MMIO_EN
    ,
    .io_out     (io_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // called at a falling edge, returns at the next falling edge
  task automatic send(input logic [7:0] b, input logic l);
    host_valid = 1'b1;
    host_byte  = b;
    host_last  = l;
    @(negedge clk);
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic l);
    send(w[15:8], 1'b0);
    send(w[7:0], l);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
    add_out = a;
    #1;
    check(tag, {16'h0, data_in}, {16'h0, exp});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    host_valid = 1'b0;
    host_byte  = 8'h00;
    host_last  = 1'b0;
    add_out    = 8'h00;
    data_out   = 8'h00;
    MW         = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_ready", {31'h0, host_ready}, 32'd1);
    check("rst_run",   {31'h0, cpu_run}, 32'd0);
    check("rst_words", {23'h0, load_words}, 32'd0);
    check("rst_ovf",   {31'h0, overflow}, 32'd0);

    // basic 2-word image with an idle gap
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    @(negedge clk);
    check("t1_hold_words", {23'h0, load_words}, 32'd1);
    send(8'h56, 1'b0);
    host_valid = 1'b1; host_byte = 8'h78; host_last = 1'b1;
    #1;
    check("t1_run_before_edge", {31'h0, cpu_run}, 32'd0);
    @(negedge clk);
    host_valid = 1'b0; host_last = 1'b0;
    check("t1_run",   {31'h0, cpu_run}, 32'd1);
    check("t1_ready", {31'h0, host_ready}, 32'd0);
    check("t1_words", {23'h0, load_words}, 32'd2);
    rd("t1_mem0", 8'h00, 16'h1234);
    rd("t1_mem1", 8'h01, 16'h5678);
    send(8'h99, 1'b1);
    check("t1_ign_words", {23'h0, load_words}, 32'd2);
    check("t1_ign_run",   {31'h0, cpu_run}, 32'd1);

    // 6-word image then CPU read-during-write on word 5
    do_reset();
    for (int i = 0; i < 5; i++) send_word(16'h0001 + 16'(i), 1'b0);
    send_word(16'hA5A5, 1'b1);
    check("t3_words", {23'h0, load_words}, 32'd6);
    rd("t3_mem2", 8'h02, 16'h0003);
    add_out = 8'h05; data_out = 8'h3C; MW = 1'b1;
    #1;
    check("t3_rdw_old", {16'h0, data_in}, 32'h0000A5A5);
    @(negedge clk);
    MW = 1'b0;
    check("t3_rdw_new", {16'h0, data_in}, 32'h0000A53C);

    // odd image, MW held during load must be ignored, RAM survives reset
    do_reset();
    add_out = 8'h05; data_out = 8'h11; MW = 1'b1;
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b0);
    send(8'hEF, 1'b1);
    MW = 1'b0;
    check("t2_words", {23'h0, load_words}, 32'd2);
    check("t2_run",   {31'h0, cpu_run}, 32'd1);
    rd("t2_mem0", 8'h00, 16'hABCD);
    rd("t2_mem1", 8'h01, 16'hEF00);
    rd("t2_mem5", 8'h05, 16'hA53C);

    // reset in the middle of a word restarts at word 0 in LOAD_HI
    do_reset();
    send_word(16'h2001, 1'b0);
    send_word(16'h2002, 1'b0);
    send_word(16'h2003, 1'b0);
    send(8'h77, 1'b0);
    do_reset();
    check("t5_ready", {31'h0, host_ready}, 32'd1);
    check("t5_words", {23'h0, load_words}, 32'd0);
    check("t5_run",   {31'h0, cpu_run}, 32'd0);
    send(8'h44, 1'b0);
    send(8'h55, 1'b1);
    rd("t5_mem0", 8'h00, 16'h4455);
    rd("t5_mem1", 8'h01, 16'h2002);
    check("t5_reload_words", {23'h0, load_words}, 32'd1);

    // 257 words without last: wrap, overflow, saturation
    do_reset();
    for (int k = 0; k < 255; k++) send_word(16'h1000 + 16'(k), 1'b0);
    check("t4_ovf_255",   {31'h0, overflow}, 32'd0);
    check("t4_words_255", {23'h0, load_words}, 32'd255);
    send_word(16'h10FF, 1'b0);
    check("t4_ovf_256",   {31'h0, overflow}, 32'd1);
    check("t4_words_256", {23'h0, load_words}, 32'd256);
    send_word(16'h1100, 1'b0);
    check("t4_words_sat", {23'h0, load_words}, 32'd256);
    check("t4_ready",     {31'h0, host_ready}, 32'd1);
    rd("t4_mem0", 8'h00, 16'h1100);
    rd("t4_mem1", 8'h01, 16'h1001);
    send_word(16'h7788, 1'b1);
    check("t4_end_words", {23'h0, load_words}, 32'd256);
    check("t4_end_run",   {31'h0, cpu_run}, 32'd1);
    check("t4_end_ovf",   {31'h0, overflow}, 32'd1);
    rd("t4_mem1_last", 8'h01, 16'h7788);

    // CPU write to address FF: output port or ordinary RAM
`ifdef MMIO_EN
    rd("t6_io_pre", 8'hFF, 16'h0000);
`else
    rd("t6_ram_pre", 8'hFF, 16'h10FF);
`endif
    add_out = 8'hFF; data_out = 8'h5A; MW = 1'b1;
    @(negedge clk);
    MW = 1'b0;
`ifdef MMIO_EN
    check("t6_io_out", {24'h0, io_out}, 32'h5A);
    rd("t6_io_rd", 8'hFF, 16'h005A);
`else
    rd("t6_ram_ff", 8'hFF, 16'h105A);
`endif
    rd("t6_mem_fe", 8'hFE, 16'h10FE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
